// File: rtl/shift_reg_universal_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_universal_if
// Description : Control/data bundle for shift_reg_universal.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_reg_universal_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
);
    localparam int c_FRAME = WIDTH / LANES;
    localparam int c_CW    = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;

    logic                en;
    logic [2:0]          mode;
    logic [LANES-1:0]    d;
    logic [WIDTH-1:0]    load_data;
    logic [WIDTH-1:0]    out;
    logic [LANES-1:0]    sout;
    logic [c_CW-1:0]     count;
    logic                frame_done;

    modport master (
        output en, mode, d, load_data,
        input  out, sout, count, frame_done
    );

    modport slave (
        input  en, mode, d, load_data,
        output out, sout, count, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_universal
// Description : Multi-lane universal shift/rotate register with frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    shift_reg_universal_if.slave  bus
);
    localparam int c_FRAME = WIDTH / LANES;
    localparam int c_CW    = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_FRAME - 1);

    localparam logic [2:0] c_MODE_SHL   = 3'b001;
    localparam logic [2:0] c_MODE_SHR   = 3'b010;
    localparam logic [2:0] c_MODE_ROL   = 3'b011;
    localparam logic [2:0] c_MODE_ROR   = 3'b100;
    localparam logic [2:0] c_MODE_LOAD  = 3'b101;
    localparam logic [2:0] c_MODE_CLEAR = 3'b110;

    logic [WIDTH-1:0] r_out;
    logic [c_CW-1:0]  r_count;
    logic             r_frame_done;
    logic             w_shift_op;

    assign w_shift_op = bus.en && (bus.mode == c_MODE_SHL || bus.mode == c_MODE_SHR ||
                                   bus.mode == c_MODE_ROL || bus.mode == c_MODE_ROR);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out        <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.en) begin
                case (bus.mode)
                    c_MODE_SHL:   r_out <= {r_out[WIDTH-1-LANES:0], bus.d};
                    c_MODE_SHR:   r_out <= {bus.d, r_out[WIDTH-1:LANES]};
                    c_MODE_ROL:   r_out <= {r_out[WIDTH-1-LANES:0], r_out[WIDTH-1 -: LANES]};
                    c_MODE_ROR:   r_out <= {r_out[LANES-1:0], r_out[WIDTH-1:LANES]};
                    c_MODE_LOAD:  r_out <= bus.load_data;
                    c_MODE_CLEAR: r_out <= '0;
                    default:      r_out <= r_out;
                endcase
                if (bus.mode == c_MODE_LOAD || bus.mode == c_MODE_CLEAR) begin
                    r_count <= '0;
                end
            end
            // Wrap at the last slot of a frame and flag the completed frame
            if (w_shift_op) begin
                if (r_count == c_LAST) begin
                    r_count      <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_count <= r_count + c_CW'(1);
                end
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.count      = r_count;
    assign bus.frame_done = r_frame_done;
    assign bus.sout       = (bus.mode == c_MODE_SHL || bus.mode == c_MODE_ROL) ?
                            r_out[WIDTH-1 -: LANES] : r_out[LANES-1:0];
endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_universal
// Description : Directed bench for shift_reg_universal (8x1 and 8x2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_universal;
    localparam logic [2:0] c_HOLD = 3'b000, c_SHL = 3'b001, c_SHR = 3'b010,
                           c_ROL = 3'b011, c_ROR = 3'b100, c_LOAD = 3'b101,
                           c_CLEAR = 3'b110, c_RSVD = 3'b111;

    logic clk;
    logic rstn_a, rstn_b;
    int   n_total = 0;
    int   n_pass  = 0;

    shift_reg_universal_if #(.WIDTH(8), .LANES(1)) ifa ();
    shift_reg_universal_if #(.WIDTH(8), .LANES(2)) ifb ();

    shift_reg_universal #(.WIDTH(8), .LANES(1)) u_a (.clk(clk), .rstn(rstn_a), .bus(ifa));
    shift_reg_universal #(.WIDTH(8), .LANES(2)) u_b (.clk(clk), .rstn(rstn_b), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [2:0] m, input logic d, input logic [7:0] ld);
        ifa.en = en; ifa.mode = m; ifa.d = d; ifa.load_data = ld;
    endtask

    task automatic drive_b(input logic en, input logic [2:0] m, input logic [1:0] d, input logic [7:0] ld);
        ifb.en = en; ifb.mode = m; ifb.d = d; ifb.load_data = ld;
    endtask

    initial begin
        logic [7:0] shl_bits;
        logic [1:0] sout_exp [4];

        // Reset dominates an active LOAD of all ones
        rstn_a = 1'b0; rstn_b = 1'b0;
        drive_a(1'b1, c_LOAD, 1'b0, 8'hFF);
        drive_b(1'b1, c_LOAD, 2'b00, 8'hFF);
        tick(); tick();
        chk("rst_a_out", ifa.out, 8'h00);
        chk("rst_a_count", ifa.count, 3'd0);
        chk("rst_a_fd", ifa.frame_done, 1'b0);
        chk("rst_b_out", ifb.out, 8'h00);
        chk("rst_b_count", ifb.count, 2'd0);
        rstn_a = 1'b1; rstn_b = 1'b1;
        drive_b(1'b0, c_HOLD, 2'b00, 8'h00);

        // SHL serial, 8x1
        drive_a(1'b1, c_CLEAR, 1'b0, 8'h00);
        tick();
        chk("clr_out", ifa.out, 8'h00);
        shl_bits = 8'b10110010;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, c_SHL, shl_bits[7-i], 8'h00);
            if (i == 7) chk("shl_sout_pre8", ifa.sout, 1'b0);
            tick();
            chk("shl_count", ifa.count, (i + 1) % 8);
            chk("shl_fd", ifa.frame_done, (i == 7) ? 1'b1 : 1'b0);
        end
        chk("shl_out", ifa.out, 8'b10110010);
        drive_a(1'b1, c_HOLD, 1'b0, 8'h00);
        tick();
        chk("shl_fd_clear", ifa.frame_done, 1'b0);
        chk("hold_out", ifa.out, 8'b10110010);

        // SHR, 8x2, LSB-first lanes
        drive_b(1'b1, c_LOAD, 2'b00, 8'hA5);
        tick();
        chk("shr_load", ifb.out, 8'hA5);
        sout_exp[0] = 2'b01; sout_exp[1] = 2'b01; sout_exp[2] = 2'b10; sout_exp[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b1, c_SHR, 2'b11, 8'h00);
            #1;
            chk("shr_sout", ifb.sout, sout_exp[i]);
            tick();
            chk("shr_fd", ifb.frame_done, (i == 3) ? 1'b1 : 1'b0);
        end
        chk("shr_out", ifb.out, 8'hFF);
        chk("shr_count", ifb.count, 2'd0);

        // LOAD at the last slot of a frame resets count without a pulse
        drive_b(1'b1, c_SHR, 2'b00, 8'h00);
        tick(); tick(); tick();
        chk("b_count3", ifb.count, 2'd3);
        chk("b_out3", ifb.out, 8'h03);
        drive_b(1'b1, c_LOAD, 2'b00, 8'h3C);
        tick();
        chk("load_last_out", ifb.out, 8'h3C);
        chk("load_last_count", ifb.count, 2'd0);
        chk("load_last_fd", ifb.frame_done, 1'b0);
        drive_b(1'b1, c_CLEAR, 2'b00, 8'h00);
        tick();
        chk("b_clear", ifb.out, 8'h00);
        drive_b(1'b0, c_HOLD, 2'b00, 8'h00);

        // Rotate, 8x1: +1 -2 +3 -2 returns to the loaded value
        drive_a(1'b1, c_LOAD, 1'b0, 8'h81);
        tick();
        drive_a(1'b1, c_ROL, 1'b0, 8'h00);
        #1;
        chk("rol_sout", ifa.sout, 1'b1);
        tick();
        chk("rol1", ifa.out, 8'h03);
        drive_a(1'b1, c_ROR, 1'b0, 8'h00);
        #1;
        chk("ror_sout", ifa.sout, 1'b1);
        tick(); tick();
        chk("ror2", ifa.out, 8'hC0);
        chk("rot_count3", ifa.count, 3'd3);
        drive_a(1'b1, c_ROL, 1'b1, 8'h00);
        tick(); tick(); tick();
        chk("rol3", ifa.out, 8'h06);
        drive_a(1'b1, c_ROR, 1'b0, 8'h00);
        tick();
        chk("rot_fd_early", ifa.frame_done, 1'b0);
        tick();
        chk("rot_out_back", ifa.out, 8'h81);
        chk("rot_fd", ifa.frame_done, 1'b1);
        chk("rot_count0", ifa.count, 3'd0);

        // Enable low freezes state mid-frame
        drive_a(1'b1, c_LOAD, 1'b0, 8'h00);
        tick();
        drive_a(1'b1, c_SHL, 1'b1, 8'h00);
        tick(); tick(); tick();
        chk("en_pre_count", ifa.count, 3'd3);
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b0, c_SHL, i[0], 8'h00);
            tick();
            chk("en0_out", ifa.out, 8'h07);
            chk("en0_count", ifa.count, 3'd3);
            chk("en0_fd", ifa.frame_done, 1'b0);
        end
        drive_a(1'b1, c_SHL, 1'b0, 8'h00);
        tick(); tick(); tick(); tick();
        chk("resume_count7", ifa.count, 3'd7);
        chk("resume_fd_early", ifa.frame_done, 1'b0);
        tick();
        chk("resume_out", ifa.out, 8'hE0);
        chk("resume_fd", ifa.frame_done, 1'b1);

        // Reset mid-frame at count 5
        drive_a(1'b1, c_SHL, 1'b1, 8'h00);
        tick(); tick(); tick(); tick(); tick();
        chk("mid_count5", ifa.count, 3'd5);
        chk("mid_out", ifa.out, 8'h1F);
        rstn_a = 1'b0;
        tick();
        chk("mid_rst_out", ifa.out, 8'h00);
        chk("mid_rst_count", ifa.count, 3'd0);
        chk("mid_rst_fd", ifa.frame_done, 1'b0);
        rstn_a = 1'b1;
        drive_a(1'b1, c_HOLD, 1'b0, 8'h00);
        tick();
        chk("mid_post_fd", ifa.frame_done, 1'b0);

        // Reserved mode behaves as HOLD
        drive_a(1'b1, c_LOAD, 1'b0, 8'h5A);
        tick();
        drive_a(1'b1, c_SHL, 1'b1, 8'h00);
        tick();
        chk("rsvd_pre", ifa.out, 8'hB5);
        drive_a(1'b1, c_RSVD, 1'b0, 8'hFF);
        tick(); tick();
        chk("rsvd_out", ifa.out, 8'hB5);
        chk("rsvd_count", ifa.count, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register, the successor to the fixed serial-in `shift_reg`. It adds:
- multi-lane shifting (LANES bits per cycle),
- left/right shift and rotate modes,
- synchronous parallel load and clear,
- a frame counter that flags each completed full-width shift.

It sits between the pad-level `io_in`/`io_out` wrapper and downstream logic. It serves as a serialiser/deserialiser and as a pattern generator.

## Interface
Parameters:
- WIDTH, 32, register width in bits; must be a multiple of LANES, ≥ 2.
- LANES, 1, bits shifted per cycle; 1 ≤ LANES ≤ WIDTH/2.
- Derived: FRAME = WIDTH/LANES; CW = max(1, clog2(FRAME)).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rstn  input  1  synchronous active-low reset; sampled on clk rising edge; dominates all other inputs.
- en  input  1  operation enable; 0 = hold everything.
- mode  input  3  operation select (see Operation).
- d  input  LANES  serial input lanes.
- load_data  input  WIDTH  parallel load value.
- out  output  WIDTH  register contents (registered).
- sout  output  LANES  lanes exiting on the next shift (combinational from out and mode).
- count  output  CW  shifts completed in the current frame, 0..FRAME-1 (registered).
- frame_done  output  1  one-cycle pulse after the FRAME-th shift of a frame (registered).

## Operation
The register updates on each clk rising edge when rstn=1 and en=1. Modes:
- 000 HOLD: out unchanged; count unchanged.
- 001 SHL: out ← {out[WIDTH-1-LANES:0], d}; the top LANES bits are discarded (they were on sout).
- 010 SHR: out ← {d, out[WIDTH-1:LANES]}; the bottom LANES bits are discarded.
- 011 ROL: out ← {out[WIDTH-1-LANES:0], out[WIDTH-1 -: LANES]}; d ignored.
- 100 ROR: out ← {out[LANES-1:0], out[WIDTH-1:LANES]}; d ignored.
- 101 LOAD: out ← load_data; count ← 0.
- 110 CLEAR: out ← 0; count ← 0.
- 111 reserved: behaves as HOLD.

sout:
- out[WIDTH-1 -: LANES] when mode ∈ {SHL, ROL}.
- out[LANES-1:0] for all other modes.

Counter:
- Every SHL/SHR/ROL/ROR cycle with en=1 is a shift op.
- A shift op with count < FRAME-1 increments count.
- A shift op with count = FRAME-1 wraps count to 0 and sets frame_done=1 on that edge.
- On every other edge (including en=0), frame_done ← 0. It is never high for two consecutive cycles unless shift ops at count = FRAME-1 occur back-to-back, which requires FRAME = 1 and is excluded by the parameter limits.
- A mode change between shift directions does not reset count.

Reset:
- rstn=0 at an edge: out ← 0, count ← 0, frame_done ← 0, regardless of en/mode.
- Reset mid-frame discards the partial frame; no frame_done is produced for it.

## Timing
- Latency: out, count and frame_done reflect an operation 1 cycle after the edge that sampled it.
- sout is valid combinationally in the same cycle as mode/out. Downstream must sample it before or at the edge that shifts it out.
- A full frame serialises in FRAME cycles. After LOAD at edge 0 and shift ops at edges 1..FRAME, frame_done is high in the cycle following edge FRAME.
- en=0 or HOLD freezes out and count indefinitely; frame_done clears after one edge.
- Simultaneous LOAD and a wrap are impossible (LOAD is not a shift op). LOAD at count = FRAME-1 yields count=0 with no frame_done.

## Test plan
- Reset: drive rstn=0 for 2 cycles with en=1, mode=LOAD, load_data=all-ones → out=0, count=0, frame_done=0; then release.
- SHL serial, WIDTH=8, LANES=1: after CLEAR, shift d=1,0,1,1,0,0,1,0 → out=8'b10110010; count wraps 7→0; frame_done high exactly 1 cycle after the 8th shift.
- SHR, WIDTH=8, LANES=2: LOAD 8'hA5, SHR with d=2'b11 ×4 → sout sequence 01,01,10,10 (LSB-first lanes); out=8'hFF; frame_done pulses once.
- Rotate: WIDTH=8, LANES=1, LOAD 8'h81, ROL ×1 → 8'h03; ROR ×2 → 8'hC0; after 8 total rotates a frame_done pulse occurs and out returns to its pre-rotate value.
- Hold/enable: mid-frame (count=3) drop en for 5 cycles with mode=SHL and toggling d → out and count frozen at 3, frame_done=0; resume to complete the frame.
- Reset mid-frame: at count=5 assert rstn=0 for 1 cycle → out=0, count=0, no frame_done. Mode 111 with en=1 → out unchanged.
